// File: rtl/enc_pkg.sv
// Shared FSM state type, decode step constants and the x4 quadrature step
// function used by every encoder channel of enc_sample_scheduler.
package enc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Two-bit two's complement steps, sign-extended into the position counter.
  localparam logic [1:0] STEP_POS  = 2'b01;
  localparam logic [1:0] STEP_NEG  = 2'b11;
  localparam logic [1:0] STEP_ZERO = 2'b00;

  typedef struct packed {
    logic [1:0] step;
    logic       illegal;
  } step_t;

  // AB is mapped onto its position in the Gray cycle 00,01,11,10 so the
  // step falls out of a modulo-4 difference.
  function automatic step_t quad_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] prev_pos;
    logic [1:0] cur_pos;
    logic [1:0] diff;
    step_t      res;
    prev_pos = {prev_ab[1], prev_ab[1] ^ prev_ab[0]};
    cur_pos  = {cur_ab[1], cur_ab[1] ^ cur_ab[0]};
    diff     = cur_pos - prev_pos;
    res.illegal = 1'b0;
    case (diff)
      2'd1:    res.step = STEP_POS;
      2'd3:    res.step = STEP_NEG;
      2'd2: begin
        res.step    = STEP_ZERO;
        res.illegal = 1'b1;
      end
      default: res.step = STEP_ZERO;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/enc_sample_scheduler_quad_decoder.sv
// One encoder channel: synchronizer, optional glitch filter
// (ENC_GLITCH_FILTER_EN), x4 decode, wrapping position counter, sticky illegal.
module quad_decoder
  import enc_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enc_a_i,
  input  logic               enc_b_i,
  input  logic               clr_err_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               illegal_o
);

  logic [1:0]         meta_q;
  logic [1:0]         sync_q;
  logic [1:0]         prev_q;
  logic [1:0]         cur_ab;
  logic [COUNT_W-1:0] count_q;
  logic               illegal_q;
  step_t              st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= {enc_a_i, enc_b_i};
      sync_q <= meta_q;
    end
  end

`ifdef ENC_GLITCH_FILTER_EN
  logic [2:0] hist_a_q;
  logic [2:0] hist_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_a_q <= 3'b000;
      hist_b_q <= 3'b000;
    end else begin
      hist_a_q <= {hist_a_q[1:0], sync_q[1]};
      hist_b_q <= {hist_b_q[1:0], sync_q[0]};
    end
  end

  // 2-of-3 majority: a single-cycle pulse can never win the vote.
  assign cur_ab = {(hist_a_q[0] & hist_a_q[1]) | (hist_a_q[1] & hist_a_q[2]) | (hist_a_q[0] & hist_a_q[2]),
                   (hist_b_q[0] & hist_b_q[1]) | (hist_b_q[1] & hist_b_q[2]) | (hist_b_q[0] & hist_b_q[2])};
`else
  assign cur_ab = sync_q;
`endif

  assign st = quad_step(prev_q, cur_ab);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= 2'b00;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      prev_q  <= cur_ab;
      count_q <= count_q + {{(COUNT_W-2){st.step[1]}}, st.step};
      // A fresh illegal transition outranks a simultaneous clear.
      if (st.illegal) begin
        illegal_q <= 1'b1;
      end else if (clr_err_i) begin
        illegal_q <= 1'b0;
      end
    end
  end

  assign count_o   = count_q;
  assign illegal_o = illegal_q;

endmodule

// File: rtl/enc_sample_scheduler.sv
// Multi-channel quadrature front end with a periodic round-robin delta scan.
// Build option ENC_GLITCH_FILTER_EN enables the per-bit majority filter.
module enc_sample_scheduler
  import enc_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int COUNT_W    = 16,
  parameter int SAMPLE_DIV = 50000,
  parameter int CH_W       = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    enc_a,
  input  logic [N_CH-1:0]    enc_b,
  input  logic               enable,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    out_ch,
  output logic [COUNT_W-1:0] out_delta,
  output logic               overrun,
  output logic [N_CH-1:0]    illegal,
  input  logic               clr_err
);

  localparam int TIMER_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [TIMER_W-1:0] timer_q;
  logic               tick;
  logic [COUNT_W-1:0] count   [N_CH];
  logic [COUNT_W-1:0] snap_q  [N_CH];
  logic [COUNT_W-1:0] last_q  [N_CH];
  state_e             state_q, state_d;
  logic [CH_W-1:0]    idx_q;
  logic [COUNT_W-1:0] delta_q;
  logic               overrun_q;
  logic               last_ch;
  logic               snap_en, load_en, idx_inc;

  assign tick    = enable && (timer_q == TIMER_W'(SAMPLE_DIV - 1));
  assign last_ch = (idx_q == CH_W'(N_CH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (!enable || tick) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TIMER_W'(1);
    end
  end

  // Snapshot is taken for every channel at the tick so a scan is coherent.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    quad_decoder #(.COUNT_W(COUNT_W)) u_dec (
      .clk       (clk),
      .rst_n     (rst_n),
      .enc_a_i   (enc_a[gi]),
      .enc_b_i   (enc_b[gi]),
      .clr_err_i (clr_err),
      .count_o   (count[gi]),
      .illegal_o (illegal[gi])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        snap_q[gi] <= '0;
        last_q[gi] <= '0;
      end else begin
        if (snap_en) snap_q[gi] <= count[gi];
        if (load_en && (idx_q == CH_W'(gi))) last_q[gi] <= snap_q[gi];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = LOAD;
      LOAD:    state_d = WAIT;
      WAIT:    if (out_ready) state_d = last_ch ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == WAIT);
    snap_en   = (state_q == IDLE) && tick;
    load_en   = (state_q == LOAD);
    idx_inc   = (state_q == WAIT) && out_ready && !last_ch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      delta_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (snap_en)      idx_q <= '0;
      else if (idx_inc) idx_q <= idx_q + CH_W'(1);
      if (load_en) delta_q <= snap_q[idx_q] - last_q[idx_q];
      // A tick mid-scan is dropped; only the sticky flag records it.
      if (tick && (state_q != IDLE)) overrun_q <= 1'b1;
      else if (clr_err)              overrun_q <= 1'b0;
    end
  end

  assign out_ch    = idx_q;
  assign out_delta = delta_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_enc_sample_scheduler.sv
// Randomized bench for enc_sample_scheduler: integer position model per
// channel, deltas checked as (position - position at previous sample) mod 2^16.
module tb_enc_sample_scheduler;

  localparam int N_CH       = 4;
  localparam int COUNT_W    = 16;
  localparam int SAMPLE_DIV = 40;
  localparam int CH_W       = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_CH-1:0]    enc_a, enc_b, illegal;
  logic               enable, out_valid, out_ready, overrun, clr_err;
  logic [CH_W-1:0]    out_ch;
  logic [COUNT_W-1:0] out_delta;

  int n_checks = 0;
  int n_pass   = 0;
  int pos   [N_CH];
  int last  [N_CH];
  int phase [N_CH];

  always #5 clk = ~clk;

  enc_sample_scheduler #(
    .N_CH(N_CH), .COUNT_W(COUNT_W), .SAMPLE_DIV(SAMPLE_DIV), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enable(enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_delta(out_delta), .overrun(overrun), .illegal(illegal), .clr_err(clr_err)
  );

  function automatic logic [1:0] ab_of(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // dir = +1/-1 for legal edges, 2 for a both-bits jump (no count change).
  task automatic step_ch(input int ch, input int dir, input int n);
    logic [1:0] ab;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      phase[ch] = (phase[ch] + dir + 4) % 4;
      if (dir != 2) pos[ch] += dir;
      ab = ab_of(phase[ch]);
      enc_a[ch] = ab[1];
      enc_b[ch] = ab[0];
      repeat (2) @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_scan(input bit rand_ready, input int stall_ch, input int stall_len, input bit hold_en);
    int cyc, got, stall_cnt;
    logic [COUNT_W-1:0] exp_d;
    enable = 1'b1;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < SAMPLE_DIV + 20) begin
      @(negedge clk); cyc++;
    end
    if (!hold_en) enable = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin
      $display("FAIL scan_start: out_valid=%b after %0d cycles, required 1", out_valid, cyc);
      enable = 1'b0;
      return;
    end
    n_pass++;
    got = 0; cyc = 0; stall_cnt = 0;
    while (got < N_CH && cyc < 1000) begin
      exp_d = COUNT_W'(pos[got] - last[got]);
      if (got == stall_ch && stall_cnt < stall_len && (stall_cnt > 0 || out_valid === 1'b1)) begin
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_ch !== CH_W'(got) || out_delta !== exp_d)
          $display("FAIL stall_hold: valid=%b ch=%0d delta=%h, required 1 %0d %h", out_valid, out_ch, out_delta, got, exp_d);
        else n_pass++;
        stall_cnt++;
        if (stall_cnt == stall_len) enable = 1'b0;
      end else begin
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (out_valid === 1'b1 && out_ready) begin
          n_checks++;
          if (out_ch !== CH_W'(got)) $display("FAIL sample_ch: got %0d, required %0d", out_ch, got);
          else n_pass++;
          n_checks++;
          if (out_delta !== exp_d) $display("FAIL sample_delta ch%0d: got %h, required %h", got, out_delta, exp_d);
          else n_pass++;
          $display("sample ch=%0d delta=%h expected=%h", out_ch, out_delta, exp_d);
          last[got] = pos[got];
          got++;
        end
      end
      @(negedge clk); cyc++;
    end
    out_ready = 1'b0;
    enable = 1'b0;
    if (got < N_CH) begin
      n_checks++;
      $display("FAIL scan_done: %0d samples, required %0d", got, N_CH);
    end
  endtask

  task automatic test_reset();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", out_valid); else n_pass++;
    n_checks++; if (out_ch !== '0) $display("FAIL reset_ch: got %0d, required 0", out_ch); else n_pass++;
    n_checks++; if (out_delta !== '0) $display("FAIL reset_delta: got %h, required 0", out_delta); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b, required 0", overrun); else n_pass++;
    n_checks++; if (illegal !== '0) $display("FAIL reset_illegal: got %b, required 0", illegal); else n_pass++;
  endtask

  task automatic test_single_forward();
    step_ch(1, 1, 40);
    run_scan(1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_reverse_wrap();
    step_ch(0, 1, 5);
    run_scan(1'b0, -1, 0, 1'b0);
    step_ch(0, -1, 30);
    run_scan(1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    step_ch(2, 1, 7);
    run_scan(1'b0, 2, 20, 1'b0);
  endtask

  task automatic test_overrun();
    step_ch(1, -1, 3);
    run_scan(1'b0, 1, SAMPLE_DIV + 10, 1'b1);
    n_checks++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b, required 1", overrun); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b, required 1", overrun); else n_pass++;
    pulse_clr();
    n_checks++; if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b, required 0", overrun); else n_pass++;
  endtask

  task automatic test_illegal();
    step_ch(3, 2, 1);
    n_checks++; if (illegal !== 4'b1000) $display("FAIL illegal_set: got %b, required 1000", illegal); else n_pass++;
    run_scan(1'b0, -1, 0, 1'b0);
    n_checks++; if (illegal !== 4'b1000) $display("FAIL illegal_sticky: got %b, required 1000", illegal); else n_pass++;
    pulse_clr();
    n_checks++; if (illegal !== 4'b0000) $display("FAIL illegal_clear: got %b, required 0000", illegal); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int ch = 0; ch < N_CH; ch++)
        step_ch(ch, ($urandom_range(0, 1) != 0) ? 1 : -1, $urandom_range(0, 12));
      run_scan(1'b1, -1, 0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_wait();
    int cyc;
    for (int ch = 0; ch < N_CH; ch++) step_ch(ch, 1, (4 - phase[ch]) % 4);
    step_ch(0, 1, 8);
    enable = 1'b1;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < SAMPLE_DIV + 20) begin
      @(negedge clk); cyc++;
    end
    enable = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b, required 1", out_valid); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL async_reset_valid: got %b, required 0", out_valid); else n_pass++;
    for (int ch = 0; ch < N_CH; ch++) begin
      pos[ch] = 0;
      last[ch] = 0;
    end
    @(negedge clk); rst_n = 1'b1;
    step_ch(2, 1, 6);
    run_scan(1'b0, -1, 0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    enc_a = '0; enc_b = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      pos[ch] = 0; last[ch] = 0; phase[ch] = 0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_single_forward();
    test_reverse_wrap();
    test_backpressure();
    test_overrun();
    test_illegal();
    test_random();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/enc_sample_scheduler.md
Name: enc_sample_scheduler

Overview:
- Multi-channel quadrature-encoder front end and sampling scheduler for the motor-with-encoder subsystem.
- Decodes N A/B encoder pairs (x4) into free-running per-channel position counters.
- On every sample tick, scans the channels round-robin and emits one signed position delta per channel over a valid/ready stream to the speed-loop logic.
- Owns the sample timing, so the downstream PID sees one coherent snapshot per period.

Parameters:
- N_CH, 4, number of encoder channels (1..8).
- COUNT_W, 16, position counter and delta width in bits (signed two's complement).
- SAMPLE_DIV, 50000, clk cycles per sample period (≥ 2*N_CH+2).
- CH_W, 2, width of out_ch; must be ≥ clog2(N_CH).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enc_a  in  N_CH  encoder phase A, asynchronous to clk.
- enc_b  in  N_CH  encoder phase B, asynchronous to clk.
- enable  in  1  1 = sample timer runs; 0 = timer held at 0, counters still track.
- out_valid  out  1  delta sample available.
- out_ready  in  1  consumer accepts the sample.
- out_ch  out  CH_W  channel index of the current sample.
- out_delta  out  COUNT_W  signed count change since this channel's previous sample.
- overrun  out  1  sticky: a tick arrived while a scan was in progress.
- illegal  out  N_CH  sticky per channel: A and B changed in the same synchronized cycle.
- clr_err  in  1  synchronous, one-cycle clear of overrun and illegal.

Behaviour:
- Reset values: out_valid=0, out_ch=0, out_delta=0, overrun=0, illegal=0. All counters, last-sample registers, the timer and the synchronizers are 0. FSM state is IDLE.
- Input path: 2-flop synchronizer per A/B bit, plus a previous-state register.
- Decode table, with the state ordered AB:
  - 00→01, 01→11, 11→10, 10→00: +1.
  - Reverse of each: −1.
  - No change: 0.
  - Both bits change: 0 and set illegal[ch].
- Position counters wrap modulo 2^COUNT_W.
- Latency: an input edge reaches the counter 3 clk after it appears at the pin.
- Timer: counts 0..SAMPLE_DIV-1 while enable=1. tick is asserted for one cycle when the timer reaches SAMPLE_DIV-1, and the timer then wraps to 0.
- FSM:
  - IDLE: on tick, capture a snapshot of all N_CH counters in one cycle, set idx=0, go to LOAD.
  - LOAD: out_delta = snap[idx] − last[idx], computed modulo 2^COUNT_W. This is valid when the true |delta| < 2^(COUNT_W−1). Set last[idx] = snap[idx], out_ch = idx, out_valid = 1, go to WAIT.
  - WAIT: hold out_valid, out_ch and out_delta stable until out_ready=1.
    - On handshake with idx < N_CH−1: idx++, out_valid=0, go to LOAD.
    - On handshake with idx = N_CH−1: go to IDLE.
- Throughput: at most one sample every 2 clk. A full scan takes ≥ 2*N_CH clk.
- Edges arriving during a scan count toward the next period, because the snapshot is taken at the tick.
- Tick during LOAD/WAIT: the tick is dropped, overrun is set, and the scan in progress continues unaffected.
- enable=0 mid-scan: the current scan completes and the timer is held at 0.
- clr_err and a new error in the same cycle: the error wins (flag stays 1).
- out_ready=1 while out_valid=0: ignored.
- Reset mid-scan: immediate return to IDLE, out_valid drops asynchronously, and any partial scan is discarded.

Optional Feature:
- Macro: ENC_GLITCH_FILTER_EN.
- Defined:
  - Each synchronized A/B bit passes through a 3-sample shift register and a majority vote before decode.
  - Input-to-counter latency becomes 5 clk.
  - Pulses shorter than 2 clk are rejected.
- Undefined: no filter; latency is 3 clk.
- The port list is identical in both builds.

Decomposition:
- Package enc_pkg:
  - FSM state enum: IDLE, LOAD, WAIT.
  - Decode step constants: +1, −1, 0.
  - Function quad_step(prev_ab, cur_ab) returning the step and an illegal flag.
- Sub-module quad_decoder, instantiated N_CH times. It contains the synchronizer, the optional filter, the decode, the COUNT_W counter and the illegal flag.
- The top level holds the timer, snapshot registers, last-sample registers, FSM and output stream.

Test Plan:
- Single channel forward: N_CH=4, SAMPLE_DIV=200, drive 10 forward quadrature cycles (40 edges) on ch1, out_ready=1 → per scan, ch1 delta=+40; ch0, ch2 and ch3 deltas=0; out_ch sequence 0,1,2,3.
- Reverse and wrap: preload a counter near max with 5 forward edges from 0x7FFE-equivalent, then 30 reverse edges → deltas are +5 and then −30 across the wrap, with no spurious value.
- Backpressure: hold out_ready=0 for 20 clk on ch2 → out_valid, out_ch=2 and out_delta remain stable; the scan resumes when ready rises.
- Overrun: SAMPLE_DIV=10, out_ready=0 for 30 clk → overrun=1 stays high until clr_err; the stalled scan still completes correctly.
- Illegal transition: step ch3 from AB=00 to 11 → illegal[3]=1, count unchanged; clr_err clears it.
- Reset mid-WAIT: pulse rst_n low → out_valid=0 immediately; the first scan after reset reports deltas relative to 0.
